// File: rtl/iorq_fifo_port_pkg.sv
// Shared constants for the iorq FIFO port: register offsets, status/control bit positions.
package iorq_fifo_port_pkg;

    // Port offsets relative to BASE_ADDR
    localparam int unsigned PORT_DATA = 0;
    localparam int unsigned PORT_STAT = 1;

    // Status byte layout: {full, empty, overflow, count[4:0]}
    localparam int unsigned STAT_FULL_BIT  = 7;
    localparam int unsigned STAT_EMPTY_BIT = 6;
    localparam int unsigned STAT_OVF_BIT   = 5;
    localparam int unsigned STAT_CNT_W     = 5;

    // Control byte written to the status port
    localparam int unsigned CTRL_CLR_OVF_BIT = 7;
    localparam int unsigned CTRL_FLUSH_BIT   = 0;

    // Value returned when the CPU reads the data port
    localparam logic [7:0] DATA_RD_VALUE = 8'hFF;

    localparam int unsigned BYTE_W = 8;

endpackage

// File: rtl/iorq_fifo_port_sync_fifo.sv
// Synchronous FIFO: storage, wrapping pointers and occupancy count.
// A push while full is only accepted when a pop frees a slot in the same cycle;
// flush overrides push and pop.
module sync_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned W          = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [W-1:0]          push_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [W-1:0]          rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  drop_c
);

    localparam int unsigned PTR_W = DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];

    logic do_push;
    logic do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Qualify push/pop and compute next pointers and count
    always_comb begin
        do_pop   = 1'b0;
        do_push  = 1'b0;
        drop_c   = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            do_pop  = pop && !empty;
            do_push = push && (!full || do_pop);
            drop_c  = push && full && !do_pop;

            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Write the pushed byte into the slot at the write pointer
    always_comb begin
        mem_d = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents survive reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/iorq_fifo_port.sv
// CPU I/O-mapped byte FIFO: data port pushes bytes, status port reports
// occupancy/overflow and accepts clear/flush commands.
module iorq_fifo_port
    import iorq_fifo_port_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR  = 8'h40,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic       phi,
    input  logic       reset_n,
    input  logic       iorq_tick,
    input  logic       iorq_rd,
    input  logic       wr,
    input  logic [7:0] addr,
    input  logic [7:0] dbus_in,
    output logic [7:0] dbus_out,
    output logic       dbus_oe,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready
);

    localparam logic [7:0] DATA_ADDR = BASE_ADDR + 8'(PORT_DATA);
    localparam logic [7:0] STAT_ADDR = BASE_ADDR + 8'(PORT_STAT);

    logic                fifo_full;
    logic                fifo_empty;
    logic [DEPTH_LOG2:0] fifo_count;
    logic                fifo_drop_c;

    logic data_sel_c;
    logic stat_sel_c;
    logic push_c;
    logic ctrl_wr_c;
    logic flush_c;
    logic clr_ovf_c;
    logic pop_c;

    logic overflow_q, overflow_d;
    logic [7:0] status_c;

    // Address decode; reads never reach the FIFO so they stay side-effect free
    always_comb begin
        data_sel_c = (addr == DATA_ADDR);
        stat_sel_c = (addr == STAT_ADDR);
        push_c     = iorq_tick && wr && data_sel_c;
        ctrl_wr_c  = iorq_tick && wr && stat_sel_c;
        flush_c    = ctrl_wr_c && dbus_in[CTRL_FLUSH_BIT];
        clr_ovf_c  = ctrl_wr_c && dbus_in[CTRL_CLR_OVF_BIT];
        pop_c      = out_valid && out_ready;
    end

    sync_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .W          (BYTE_W)
    ) u_fifo (
        .clk       (phi),
        .rst_n     (reset_n),
        .push      (push_c),
        .push_data (dbus_in),
        .pop       (pop_c),
        .flush     (flush_c),
        .rd_data   (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .drop_c    (fifo_drop_c)
    );

    assign out_valid = !fifo_empty;

    // Sticky overflow: a dropped push wins over a clear in the same cycle
    always_comb begin
        overflow_d = overflow_q;
        if (clr_ovf_c) begin
            overflow_d = 1'b0;
        end
        if (fifo_drop_c) begin
            overflow_d = 1'b1;
        end
    end

    // Overflow flag register
    always_ff @(posedge phi or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    // Status byte built from registered FIFO state
    always_comb begin
        status_c                   = '0;
        status_c[STAT_FULL_BIT]    = fifo_full;
        status_c[STAT_EMPTY_BIT]   = fifo_empty;
        status_c[STAT_OVF_BIT]     = overflow_q;
        status_c[STAT_CNT_W-1:0]   = STAT_CNT_W'(fifo_count);
    end

    // CPU read-back mux and bus drive enable
    always_comb begin
        dbus_oe  = 1'b0;
        dbus_out = 8'h00;
        if (iorq_rd) begin
            if (stat_sel_c) begin
                dbus_oe  = 1'b1;
                dbus_out = status_c;
            end else if (data_sel_c) begin
                dbus_oe  = 1'b1;
                dbus_out = DATA_RD_VALUE;
            end
        end
    end

endmodule

// File: tb/tb_iorq_fifo_port.sv
// Bench for iorq_fifo_port: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed status bytes and drain sequences.
module tb_iorq_fifo_port;
    import iorq_fifo_port_pkg::*;

    localparam int DEPTH = 16;

    logic       phi;
    logic       reset_n;
    logic       iorq_tick;
    logic       iorq_rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] dbus_in;
    logic [7:0] dbus_out;
    logic       dbus_oe;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    int n_cmp;
    int n_bad;
    bit chk_en;

    logic [7:0] mq[$];
    bit         m_ovf;
    bit         m_pop;
    bit         m_push;
    bit         m_ctl;
    int         m_sz;
    logic [7:0] popped[$];
    logic [7:0] sent[$];
    logic [7:0] e_dout;
    logic       e_oe;
    logic [7:0] rnd;

    iorq_fifo_port #(
        .BASE_ADDR  (8'h40),
        .DEPTH_LOG2 (4)
    ) dut (
        .phi       (phi),
        .reset_n   (reset_n),
        .iorq_tick (iorq_tick),
        .iorq_rd   (iorq_rd),
        .wr        (wr),
        .addr      (addr),
        .dbus_in   (dbus_in),
        .dbus_out  (dbus_out),
        .dbus_oe   (dbus_oe),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial phi = 1'b0;
    always #5 phi = ~phi;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_status();
        int sz;
        sz = mq.size();
        return {sz == DEPTH, sz == 0, m_ovf, 5'(sz)};
    endfunction

    // Reference model: a byte queue plus a sticky overflow bit
    always @(posedge phi or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            m_sz   = mq.size();
            m_pop  = (m_sz != 0) && out_ready;
            m_push = iorq_tick && wr && (addr == 8'h40);
            m_ctl  = iorq_tick && wr && (addr == 8'h41);
            if (m_ctl && dbus_in[0]) begin
                mq.delete();
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_push) begin
                    if (m_sz == DEPTH && !m_pop) m_ovf = 1'b1;
                    else mq.push_back(dbus_in);
                end
            end
            if (m_ctl && dbus_in[7] && !(m_push && m_sz == DEPTH && !m_pop)) m_ovf = 1'b0;
        end
    end

    // Per-cycle compare of all outputs against the model
    always @(negedge phi) begin
        if (chk_en) begin
            check("out_valid", 8'(out_valid), 8'(mq.size() != 0));
            if (mq.size() != 0) check("out_data", out_data, mq[0]);
            e_oe   = iorq_rd && (addr == 8'h40 || addr == 8'h41);
            e_dout = !iorq_rd ? 8'h00 :
                     (addr == 8'h41) ? exp_status() :
                     (addr == 8'h40) ? 8'hFF : 8'h00;
            check("dbus_oe", 8'(dbus_oe), 8'(e_oe));
            check("dbus_out", dbus_out, e_dout);
        end
    end

    // Record bytes the consumer accepts
    always @(negedge phi) begin
        if (reset_n && out_valid && out_ready) popped.push_back(out_data);
    end

    task automatic drive(input logic t, input logic w, input logic r,
                         input logic [7:0] a, input logic [7:0] d, input logic rdy);
        @(posedge phi);
        #1;
        iorq_tick = t;
        wr        = w;
        iorq_rd   = r;
        addr      = a;
        dbus_in   = d;
        out_ready = rdy;
    endtask

    task automatic idle(input logic rdy, input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, rdy);
    endtask

    task automatic push_byte(input logic [7:0] d, input logic rdy);
        drive(1'b1, 1'b1, 1'b0, 8'h40, d, rdy);
    endtask

    task automatic ctl(input logic [7:0] d, input logic rdy);
        drive(1'b1, 1'b1, 1'b0, 8'h41, d, rdy);
    endtask

    task automatic read_stat(input logic [7:0] exp, input string name);
        drive(1'b1, 1'b0, 1'b1, 8'h41, 8'h00, 1'b0);
        #1;
        check(name, dbus_out, exp);
        check("stat_oe", 8'(dbus_oe), 8'h01);
    endtask

    // Watchdog so the run always terminates
    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        n_cmp = 0; n_bad = 0; chk_en = 1'b1;
        reset_n = 1'b0; iorq_tick = 1'b0; iorq_rd = 1'b0; wr = 1'b0;
        addr = 8'h00; dbus_in = 8'h00; out_ready = 1'b0;

        repeat (3) @(posedge phi);
        #1;
        check("rst_valid", 8'(out_valid), 8'h00);
        check("rst_oe", 8'(dbus_oe), 8'h00);
        check("rst_dout", dbus_out, 8'h00);
        @(posedge phi);
        #1 reset_n = 1'b1;

        // Two pushes, no consumer
        push_byte(8'hA5, 1'b0);
        push_byte(8'h5A, 1'b0);
        read_stat(8'h02, "stat_two");
        check("head_a5", out_data, 8'hA5);
        drive(1'b1, 1'b0, 1'b1, 8'h40, 8'h00, 1'b0);
        #1;
        check("data_rd", dbus_out, 8'hFF);
        check("data_rd_oe", 8'(dbus_oe), 8'h01);

        // Unmapped addresses are ignored
        drive(1'b1, 1'b1, 1'b0, 8'h42, 8'h11, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 8'h3F, 8'h22, 1'b0);
        read_stat(8'h02, "stat_unmapped");
        drive(1'b0, 1'b0, 1'b1, 8'h42, 8'h00, 1'b0);
        #1;
        check("rd_unmapped_oe", 8'(dbus_oe), 8'h00);

        // Flush concurrent with a pop leaves the FIFO empty
        ctl(8'h01, 1'b1);
        read_stat(8'h40, "stat_flush_pop");

        // Fill past full: overflow, then drain in order
        for (int i = 0; i < 17; i++) push_byte(8'(i), 1'b0);
        read_stat(8'hB0, "stat_full_ovf");
        popped.delete();
        idle(1'b1, 16);
        idle(1'b0, 1);
        check("drain_cnt", 8'(popped.size()), 8'd16);
        for (int i = 0; i < 16 && i < popped.size(); i++) check("drain_seq", popped[i], 8'(i));
        read_stat(8'h60, "stat_drained");

        // Full with overflow, then clear+flush
        for (int i = 0; i < 17; i++) push_byte(8'(8'h20 + i), 1'b0);
        read_stat(8'hB0, "stat_full_ovf2");
        ctl(8'h81, 1'b0);
        read_stat(8'h40, "stat_clear_flush");

        // Full FIFO: push and pop in the same cycle
        for (int i = 0; i < 16; i++) push_byte(8'(8'h30 + i), 1'b0);
        popped.delete();
        push_byte(8'h77, 1'b1);
        read_stat(8'h90, "stat_full_pushpop");
        idle(1'b1, 16);
        idle(1'b0, 1);
        check("pp_cnt", 8'(popped.size()), 8'd17);
        if (popped.size() == 17) begin
            check("pp_first", popped[0], 8'h30);
            check("pp_mid", popped[15], 8'h3F);
            check("pp_last", popped[16], 8'h77);
        end
        read_stat(8'h40, "stat_pp_empty");

        // Wrap-around with interleaved push/pop
        sent.delete();
        popped.delete();
        for (int i = 0; i < 40; i++) begin
            rnd = 8'($urandom_range(0, 255));
            sent.push_back(rnd);
            push_byte(rnd, 1'($urandom_range(0, 1)));
            idle(1'b1, 1);
        end
        idle(1'b1, 2);
        idle(1'b0, 1);
        check("wrap_cnt", 8'(popped.size()), 8'd40);
        for (int i = 0; i < 40 && i < popped.size(); i++) check("wrap_seq", popped[i], sent[i]);
        read_stat(8'h40, "stat_wrap");

        // Reset mid-operation with queued data
        for (int i = 0; i < 5; i++) push_byte(8'(8'h50 + i), 1'b0);
        read_stat(8'h05, "stat_five");
        @(posedge phi);
        #1 reset_n = 1'b0;
        #1;
        check("rst_mid_valid", 8'(out_valid), 8'h00);
        idle(1'b0, 2);
        #1 reset_n = 1'b1;
        push_byte(8'h3C, 1'b0);
        read_stat(8'h01, "stat_after_reset");
        check("head_3c", out_data, 8'h3C);

        idle(1'b0, 3);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
